// File: rtl/panxi_ahbl_sram_ctrl.sv
// panxi_ahbl_sram_ctrl
//   AHB-Lite slave front end for the 1024x32 single-port TCM SRAM.
//   Reads are zero-wait. Writes are posted into a one-entry buffer that commits
//   to the SRAM on any cycle in which no read address phase owns the port.
//   Read data is merged with buffered bytes, so the bus always sees the latest
//   written value.
//
// Ports
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   HSEL..HREADY           AHB-Lite slave inputs (address and data phase)
//   HREADYOUT, HRESP       slave ready (low for one cycle on buffer conflict), always OKAY
//   HRDATA                 read data, zero outside a read data phase
//   SRAM_*                 single-port SRAM macro interface (active-low enables)
module panxi_ahbl_sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  SRAM_CEN,
  output logic [ADDR_WIDTH-1:0] SRAM_AADDR,
  output logic [DATA_WIDTH-1:0] SRAM_WDATA,
  output logic                  SRAM_GWEN,
  output logic [DATA_WIDTH-1:0] SRAM_AWEN,
  input  logic [DATA_WIDTH-1:0] SRAM_RDATA
);

  logic                  stall;
  logic                  acc;
  logic                  rd_ap;
  logic                  wr_ap;
  logic                  wr_done;
  logic                  commit;
  logic                  buf_hit;
  logic [3:0]            mask_ap;
  logic [ADDR_WIDTH-1:0] haddr_w;
  logic [DATA_WIDTH-1:0] buf_bitmask;

  logic                  rd_pend_q;
  logic                  wr_pend_q;
  logic                  buf_valid_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] buf_addr_q;
  logic [3:0]            wr_mask_q;
  logic [3:0]            buf_mask_q;
  logic [DATA_WIDTH-1:0] buf_data_q;

  // Upper address bits alias; HTRANS[0] does not distinguish SEQ from NONSEQ here.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign haddr_w = HADDR[ADDR_WIDTH+1:2];

  // A read arriving while the buffer is full and a write data phase is still open
  // would leave no free SRAM cycle for the pending commit, so hold the bus for one
  // cycle. HREADY is deliberately not part of this term: during our own write
  // data phase HREADY is our own HREADYOUT, and using it would form a loop.
  assign stall     = buf_valid_q & wr_pend_q & HSEL & HTRANS[1] & ~HWRITE;
  assign HREADYOUT = ~stall;
  assign HRESP     = 1'b0;

  assign acc     = HSEL & HTRANS[1] & HREADY & ~stall;
  assign rd_ap   = acc & ~HWRITE;
  assign wr_ap   = acc & HWRITE;
  assign wr_done = wr_pend_q & ~stall;
  assign commit  = buf_valid_q & ~rd_ap;

  always_comb begin
    mask_ap = 4'b1111;
    case (HSIZE)
      3'd0:    mask_ap = 4'b0001 << HADDR[1:0];
      3'd1:    mask_ap = HADDR[1] ? 4'b1100 : 4'b0011;
      default: mask_ap = 4'b1111;
    endcase
  end

  always_comb begin
    buf_bitmask = '0;
    for (int i = 0; i < 4; i++) begin
      buf_bitmask[i*8 +: 8] = {8{buf_mask_q[i]}};
    end
  end

  // SRAM port: a read address phase has priority, otherwise drain the buffer.
  always_comb begin
    SRAM_CEN   = 1'b1;
    SRAM_GWEN  = 1'b1;
    SRAM_AWEN  = '1;
    SRAM_AADDR = '0;
    SRAM_WDATA = '0;
    if (rd_ap) begin
      SRAM_CEN   = 1'b0;
      SRAM_AADDR = haddr_w;
    end else if (commit) begin
      SRAM_CEN   = 1'b0;
      SRAM_GWEN  = 1'b0;
      SRAM_AADDR = buf_addr_q;
      SRAM_WDATA = buf_data_q;
      SRAM_AWEN  = ~buf_bitmask;
    end
  end

  // Merge uses the buffer as it stands in the data-phase cycle; a commit in that
  // same cycle has not yet reached the SRAM read data.
  assign buf_hit = buf_valid_q & (buf_addr_q == rd_addr_q);

  always_comb begin
    HRDATA = '0;
    if (rd_pend_q) begin
      HRDATA = buf_hit ? ((SRAM_RDATA & ~buf_bitmask) | (buf_data_q & buf_bitmask))
                       : SRAM_RDATA;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      buf_addr_q  <= '0;
      wr_mask_q   <= '0;
      buf_mask_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      if (HREADYOUT) begin
        rd_pend_q <= rd_ap;
        wr_pend_q <= wr_ap;
      end
      if (rd_ap) begin
        rd_addr_q <= haddr_w;
      end
      if (wr_ap) begin
        wr_addr_q <= haddr_w;
        wr_mask_q <= mask_ap;
      end
      if (wr_done) begin
        buf_data_q  <= HWDATA;
        buf_addr_q  <= wr_addr_q;
        buf_mask_q  <= wr_mask_q;
        buf_valid_q <= 1'b1;
      end else if (commit) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

endmodule
